// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC subset: fetch T0-T2, execute T3-T7, HALT.
// Optional MEM_WAIT_EN adds mem_ready; T1, ld-T6 and st-T6 then hold until it is sampled high.
module control_sequencer #(
    parameter int         OPW    = 5,
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clk,
    input  logic        clr,
`ifdef MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    input  logic [31:0] IR_Data,
    output logic        PC_in,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        IncPC,
    output logic        PC_out,
    output logic        Zlow_out,
    output logic        MDR_out,
    output logic        C_out,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_instruction_bits,
    output logic        Run
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [OPW-1:0]   opcode_q;
    logic             mem_ok;
    logic             unused_ir;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif
    assign unused_ir = ^IR_Data[31-OPW:0];

    logic is_ld, is_ldi, is_st, is_mem, is_r, is_imm, is_halt;
    logic [4:0] imm_alu;
    assign is_ld   = (opcode_q == 5'b00000);
    assign is_ldi  = (opcode_q == 5'b00001);
    assign is_st   = (opcode_q == 5'b00010);
    assign is_mem  = is_ld | is_ldi | is_st;
    assign is_r    = (opcode_q >= 5'b00011) && (opcode_q <= 5'b01011);
    assign is_imm  = (opcode_q >= 5'b01100) && (opcode_q <= 5'b01110);
    assign is_halt = (opcode_q == 5'b11011);

    always_comb begin
        case (opcode_q)
            5'b01101: imm_alu = 5'b01010;
            5'b01110: imm_alu = 5'b01011;
            default:  imm_alu = 5'b00011;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_RESET;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            // Opcode captured on the T2->T3 edge, stable for the whole execute phase
            if (state_q == S_T2) opcode_q <= IR_Data[31 -: OPW];
        end
    end

    always_comb begin
        state_d  = state_q;
        PC_in    = 1'b0; IR_in   = 1'b0; Y_in   = 1'b0; Z_in  = 1'b0;
        MAR_in   = 1'b0; MDR_in  = 1'b0; IncPC  = 1'b0; PC_out = 1'b0;
        Zlow_out = 1'b0; MDR_out = 1'b0; C_out  = 1'b0; Read  = 1'b0;
        Write    = 1'b0; Gra     = 1'b0; Grb    = 1'b0; Grc   = 1'b0;
        Rin      = 1'b0; Rout    = 1'b0; BAout  = 1'b0;
        alu_instruction_bits = 5'b0;
        Run      = 1'b1;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1;
                if (mem_ok) state_d = S_T2;
            end
            S_T2: begin
                MDR_out = 1'b1; IR_in = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_mem) begin
                    Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; state_d = S_T4;
                end else if (is_r || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; state_d = S_T4;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4: begin
                Z_in = 1'b1;
                state_d = S_T5;
                if (is_mem) begin
                    C_out = 1'b1; alu_instruction_bits = ADD_OP;
                end else if (is_r) begin
                    Grc = 1'b1; Rout = 1'b1; alu_instruction_bits = opcode_q;
                end else begin
                    C_out = 1'b1; alu_instruction_bits = imm_alu;
                end
            end
            S_T5: begin
                Zlow_out = 1'b1;
                if (is_ld || is_st) begin
                    MAR_in = 1'b1; state_d = S_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1; state_d = S_T0;
                end
            end
            S_T6: begin
                if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1; Write = 1'b1;
                    if (mem_ok) state_d = S_T0;
                end else begin
                    Read = 1'b1; MDR_in = 1'b1;
                    if (mem_ok) state_d = S_T7;
                end
            end
            S_T7: begin
                MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                state_d = S_T0;
            end
            S_HALT: Run = 1'b0;
            default: state_d = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus queues the expected {Run, alu, strobes} per cycle, a negedge monitor compares.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic [31:0] IR_Data = 32'h0;
`ifdef MEM_WAIT_EN
    logic mem_ready = 1'b1;
`endif
    logic PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, IncPC, PC_out, Zlow_out, MDR_out;
    logic C_out, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Run;
    logic [4:0] alu_instruction_bits;

    control_sequencer dut (
        .clk(clk), .clr(clr),
`ifdef MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .IR_Data(IR_Data),
        .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .MAR_in(MAR_in),
        .MDR_in(MDR_in), .IncPC(IncPC), .PC_out(PC_out), .Zlow_out(Zlow_out),
        .MDR_out(MDR_out), .C_out(C_out), .Read(Read), .Write(Write), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_instruction_bits(alu_instruction_bits), .Run(Run)
    );

    always #5 clk = ~clk;

    localparam logic [24:0] PCI = 25'd1 << 18, IRI = 25'd1 << 17, YI  = 25'd1 << 16,
        ZI  = 25'd1 << 15, MARI = 25'd1 << 14, MDRI = 25'd1 << 13, INC = 25'd1 << 12,
        PCO = 25'd1 << 11, ZLO  = 25'd1 << 10, MDRO = 25'd1 << 9,  CO  = 25'd1 << 8,
        RD  = 25'd1 << 7,  WR   = 25'd1 << 6,  GRA  = 25'd1 << 5,  GRB = 25'd1 << 4,
        GRC = 25'd1 << 3,  RIN  = 25'd1 << 2,  ROUT = 25'd1 << 1,  BAO = 25'd1,
        RUN = 25'd1 << 24;
    localparam logic [24:0] BUSDRV = PCO | ZLO | MDRO | CO | ROUT | BAO;

    localparam logic [24:0] F0 = RUN | PCO | MARI | INC | ZI;
    localparam logic [24:0] F1 = RUN | ZLO | PCI | RD | MDRI;
    localparam logic [24:0] F2 = RUN | MDRO | IRI;
    localparam logic [24:0] LD3 = RUN | GRB | BAO | YI;
    localparam logic [24:0] LD4 = RUN | CO | ZI | (25'd3 << 19);
    localparam logic [24:0] LD5 = RUN | ZLO | MARI;
    localparam logic [24:0] LD6 = RUN | RD | MDRI;
    localparam logic [24:0] LD7 = RUN | MDRO | GRA | RIN;
    localparam logic [24:0] ST6 = RUN | GRA | ROUT | MDRI | WR;
    localparam logic [24:0] WB5 = RUN | ZLO | GRA | RIN;
    localparam logic [24:0] R3  = RUN | GRB | ROUT | YI;

    logic [24:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    function automatic logic [24:0] alu(input logic [4:0] c);
        return 25'(c) << 19;
    endfunction

    task automatic step(input logic [24:0] v);
        exp_q.push_back(v);
        @(posedge clk); #1;
    endtask

    task automatic do_clr(input int n);
        clr = 1'b1;
        repeat (n) step(RUN);
        clr = 1'b0;
        step(RUN);
    endtask

    task automatic fetch(input logic [31:0] ir);
        IR_Data = ir;
        step(F0); step(F1); step(F2);
    endtask

    task automatic reg_op(input logic [31:0] ir, input logic [24:0] t4);
        fetch(ir);
        step(R3); step(t4); step(WB5);
    endtask

    always @(negedge clk) begin
        logic [24:0] act;
        act = {Run, alu_instruction_bits, PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, IncPC,
               PC_out, Zlow_out, MDR_out, C_out, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};
        cyc++;
        checks++;
        if ($countones(act & BUSDRV) > 1) begin
            errors++;
            $display("FAIL bus_onehot cycle %0d: drivers %h, required at most one", cyc, act & BUSDRV);
        end
        if (exp_q.size() > 0) begin
            logic [24:0] e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ctrl_vec cycle %0d: got %h expected %h", cyc, act, e);
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        do_clr(2);
        // st $90(R4),R4
        fetch(32'h12200090); step(LD3); step(LD4); step(LD5); step(ST6);
        // ld R0,$F7
        fetch(32'h000000F7); step(LD3); step(LD4); step(LD5); step(LD6); step(LD7);
        // ldi
        fetch(32'h08000000); step(LD3); step(LD4); step(WB5);
        reg_op(32'h1A9B8000, RUN | GRC | ROUT | ZI | alu(5'b00011));  // add
        reg_op(32'h20000000, RUN | GRC | ROUT | ZI | alu(5'b00100));  // sub
        reg_op(32'h48000000, RUN | GRC | ROUT | ZI | alu(5'b01001));  // rol
        reg_op(32'h58000000, RUN | GRC | ROUT | ZI | alu(5'b01011));  // or
        reg_op(32'h60000000, RUN | CO | ZI | alu(5'b00011));          // addi
        reg_op(32'h68000000, RUN | CO | ZI | alu(5'b01010));          // andi
        reg_op(32'h70000000, RUN | CO | ZI | alu(5'b01011));          // ori
        fetch(32'hD0000000); step(RUN);                              // nop
        fetch(32'hF8000000); step(RUN);                              // unsupported
`ifdef MEM_WAIT_EN
        fetch(32'h000000F7); step(LD3); step(LD4); step(LD5);
        mem_ready = 1'b0;
        repeat (3) step(LD6);
        mem_ready = 1'b1;
        step(LD6); step(LD7);
`endif
        // clr mid-instruction
        fetch(32'h000000F7); step(LD3); step(LD4);
        do_clr(1);
        // halt, then stay halted for 20 cycles
        fetch(32'hD8000000); step(RUN);
        repeat (20) step(25'd0);
        do_clr(1);
        fetch(32'hD0000000); step(RUN);
        repeat (4) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
